argmax_scorer: RTL and testbench
================================

Name: argmax_scorer

Overview:
- Downstream consumer of the CNN output vector.
- Accepts one packed vector of NUM_CLASSES signed scores over a helpful valid/ready handshake.
- Scans the scores sequentially to find the argmax, compares it against the expected label, and presents the result over a valid/yumi handshake.
- Keeps pass/test counters and flags completion after NUM_TESTS results have been consumed.

Parameters:
- NUM_CLASSES, 10: number of scores per vector; must be >= 2.
- WORD_SIZE, 16: width of each signed two's-complement score.
- LABEL_WIDTH, 4: width of label and class index; 2^LABEL_WIDTH >= NUM_CLASSES.
- COUNT_WIDTH, 16: width of the pass and test counters.
- NUM_TESTS, 10: number of results after which all_done_o asserts.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: reset.
- valid_i, input, 1: input vector valid.
- ready_o, output, 1: block can accept a vector.
- data_i, input, NUM_CLASSES*WORD_SIZE: scores; score k is at [k*WORD_SIZE +: WORD_SIZE].
- label_i, input, LABEL_WIDTH: expected class, sampled together with data_i.
- valid_o, output, 1: result valid.
- yumi_i, input, 1: consumer takes the result this cycle.
- class_o, output, LABEL_WIDTH: argmax index.
- max_o, output, WORD_SIZE: winning score.
- match_o, output, 1: class_o == latched label.
- pass_count_o, output, COUNT_WIDTH: results consumed with match.
- test_count_o, output, COUNT_WIDTH: results consumed.
- all_done_o, output, 1: test_count_o >= NUM_TESTS.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - valid_o, class_o, max_o, match_o, pass_count_o, test_count_o, all_done_o all 0.
  - ready_o is 1 in the first cycle after reset (NUM_TESTS > 0).
  - Reset mid-scan or in DONE aborts the vector; no counter update.
- State IDLE:
  - ready_o = !all_done_o.
  - On valid_i && ready_o at edge T: latch data_i and label_i; best = score0, best_idx = 0, idx = 1; go to SCAN.
  - valid_i is ignored while ready_o = 0.
- State SCAN:
  - ready_o = 0, valid_o = 0.
  - Each cycle: if signed score[idx] > best (strict), best = score[idx] and best_idx = idx. Then idx++.
  - Ties keep the lower index.
  - After processing idx = NUM_CLASSES-1, go to DONE.
  - The scan occupies cycles T+1 .. T+NUM_CLASSES-1.
- State DONE:
  - valid_o = 1, class_o = best_idx, max_o = best, match_o = (best_idx == label).
  - valid_o first asserts in cycle T+NUM_CLASSES (10 cycles after the accept edge at defaults).
  - Outputs are held stable until yumi_i.
  - On yumi_i:
    - test_count_o increments.
    - pass_count_o increments if match_o.
    - Both counters saturate at all-ones.
    - valid_o drops next cycle; go to IDLE.
  - There is no same-cycle bypass: ready_o rises the cycle after yumi_i. Minimum initiation interval is NUM_CLASSES+1 cycles.
- yumi_i while valid_o = 0 is illegal; the block ignores it and makes no state or counter change.
- all_done_o is registered. It rises the cycle after the yumi that makes test_count_o reach NUM_TESTS and stays high until reset.
- class_o, max_o, match_o hold their last values outside DONE. Only valid_o qualifies them.
- Arithmetic: scores are compared as signed WORD_SIZE values. No widening is needed; max_o is the raw winning word.

Test Plan:
- Reset: assert reset_i for 2 cycles -> all outputs 0 except ready_o = 1; counters 0.
- Basic argmax: scores {0:5, 3:-2, 7:300, others 1}, label 7, yumi_i held high -> valid_o in cycle T+10, class_o = 7, max_o = 300, match_o = 1; next cycle test_count_o = 1, pass_count_o = 1.
- Negatives and ties: all scores -100 except indices 2 and 6 = -3, label 6 -> class_o = 2, max_o = 0xFFFD, match_o = 0; after yumi, pass_count_o unchanged.
- Backpressure: hold yumi_i low for 5 cycles after valid_o, with valid_i high and new data_i applied -> outputs stable, ready_o = 0, new vector not accepted; yumi -> ready_o = 1 next cycle, then the new vector is accepted.
- Completion: NUM_TESTS = 3; stream 3 vectors (2 matching) -> all_done_o = 1 after the third yumi, pass = 2, test = 3; a 4th valid_i is never accepted (ready_o = 0).
- Reset mid-scan: accept a vector, assert reset_i at T+4 -> no valid_o, counters 0; the next vector processes normally.

Source files
------------

// File: rtl/argmax_scorer_if.sv
// Score-vector input and argmax-result output handshakes of argmax_scorer.
// The producer/consumer side uses master; the scorer uses slave.
interface argmax_scorer_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned LABEL_WIDTH = 4
);
  logic                              valid_i;
  logic                              ready_o;
  logic [NUM_CLASSES*WORD_SIZE-1:0]  data_i;
  logic [LABEL_WIDTH-1:0]            label_i;
  logic                              valid_o;
  logic                              yumi_i;
  logic [LABEL_WIDTH-1:0]            class_o;
  logic [WORD_SIZE-1:0]              max_o;
  logic                              match_o;

  modport master (
    output valid_i, data_i, label_i, yumi_i,
    input  ready_o, valid_o, class_o, max_o, match_o
  );

  modport slave (
    input  valid_i, data_i, label_i, yumi_i,
    output ready_o, valid_o, class_o, max_o, match_o
  );
endinterface

// File: rtl/argmax_scorer.sv
// Sequential argmax over one latched score vector, checked against the
// expected label, with saturating pass/test counters and a completion flag.
module argmax_scorer #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned LABEL_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned NUM_TESTS   = 10
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  argmax_scorer_if.slave         bus,
  output logic [COUNT_WIDTH-1:0] pass_count_o,
  output logic [COUNT_WIDTH-1:0] test_count_o,
  output logic                   all_done_o
);

  localparam int unsigned VEC_W = NUM_CLASSES * WORD_SIZE;
  localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q;
  logic [VEC_W-1:0]       data_q;
  logic [LABEL_WIDTH-1:0] label_q;
  logic [WORD_SIZE-1:0]   best_q;
  logic [LABEL_WIDTH-1:0] best_idx_q;
  logic [LABEL_WIDTH-1:0] idx_q;

  logic [WORD_SIZE-1:0]   cur_score;
  logic                   better;
  logic [WORD_SIZE-1:0]   nxt_best;
  logic [LABEL_WIDTH-1:0] nxt_idx;
  logic [COUNT_WIDTH-1:0] test_nxt;
  logic [COUNT_WIDTH-1:0] pass_nxt;
  logic                   done_nxt;

  // One compare per scan cycle; strict > keeps the lower index on ties.
  always_comb begin
    cur_score = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == LABEL_WIDTH'(k)) cur_score = data_q[k*WORD_SIZE +: WORD_SIZE];
    end
    better   = $signed(cur_score) > $signed(best_q);
    nxt_best = better ? cur_score : best_q;
    nxt_idx  = better ? idx_q : best_idx_q;
  end

  // Saturating counter updates and the completion flag for the yumi edge.
  always_comb begin
    test_nxt = (&test_count_o) ? test_count_o : test_count_o + COUNT_WIDTH'(1);
    pass_nxt = (&pass_count_o) ? pass_count_o : pass_count_o + COUNT_WIDTH'(1);
    done_nxt = all_done_o || (test_nxt >= COUNT_WIDTH'(NUM_TESTS));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      data_q       <= '0;
      label_q      <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      idx_q        <= '0;
      bus.ready_o  <= 1'b1;
      bus.valid_o  <= 1'b0;
      bus.class_o  <= '0;
      bus.max_o    <= '0;
      bus.match_o  <= 1'b0;
      pass_count_o <= '0;
      test_count_o <= '0;
      all_done_o   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_i && bus.ready_o) begin
            data_q      <= bus.data_i;
            label_q     <= bus.label_i;
            best_q      <= bus.data_i[WORD_SIZE-1:0];
            best_idx_q  <= '0;
            idx_q       <= LABEL_WIDTH'(1);
            bus.ready_o <= 1'b0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          best_q     <= nxt_best;
          best_idx_q <= nxt_idx;
          idx_q      <= idx_q + LABEL_WIDTH'(1);
          // Result is registered on the edge that processes the last index.
          if (idx_q == LAST_IDX) begin
            bus.valid_o <= 1'b1;
            bus.class_o <= nxt_idx;
            bus.max_o   <= nxt_best;
            bus.match_o <= (nxt_idx == label_q);
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.yumi_i) begin
            bus.valid_o  <= 1'b0;
            test_count_o <= test_nxt;
            if (bus.match_o) pass_count_o <= pass_nxt;
            all_done_o   <= done_nxt;
            bus.ready_o  <= !done_nxt;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_scorer.sv
// Directed bench for argmax_scorer: latency, ties, signed compare,
// backpressure, completion and reset abort, run with NUM_TESTS = 3.
module tb_argmax_scorer;

  localparam int unsigned NC = 10;
  localparam int unsigned WS = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned NT = 3;

  logic clk = 1'b0;
  logic reset;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] test_count;
  logic all_done;

  always #5 clk = ~clk;

  argmax_scorer_if #(.NUM_CLASSES(NC), .WORD_SIZE(WS), .LABEL_WIDTH(LW)) bus ();

  argmax_scorer #(
    .NUM_CLASSES(NC), .WORD_SIZE(WS), .LABEL_WIDTH(LW),
    .COUNT_WIDTH(CW), .NUM_TESTS(NT)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus),
    .pass_count_o (pass_count),
    .test_count_o (test_count),
    .all_done_o   (all_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*WS-1:0] fill(input logic [WS-1:0] v);
    logic [NC*WS-1:0] r;
    for (int k = 0; k < NC; k++) r[k*WS +: WS] = v;
    return r;
  endfunction

  // Waits (bounded) for ready_o, then spends the accept edge.
  task automatic accept(input logic [NC*WS-1:0] vec, input logic [LW-1:0] lbl, input string tag);
    int n;
    bus.valid_i = 1'b1;
    bus.data_i  = vec;
    bus.label_i = lbl;
    n = 0;
    while (!bus.ready_o && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    tick();
    bus.valid_i = 1'b0;
  endtask

  // valid_o must be low 8 edges after accept and high after the 9th.
  task automatic scan_to_done(input string tag);
    repeat (8) tick();
    check({tag, "_busy"}, 32'(bus.valid_o), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
  endtask

  task automatic check_result(input string tag, input int cls, input logic [WS-1:0] mx, input bit m);
    check({tag, "_class"}, 32'(bus.class_o), 32'(cls));
    check({tag, "_max"}, 32'(bus.max_o), 32'(mx));
    check({tag, "_match"}, 32'(bus.match_o), 32'(m));
  endtask

  task automatic check_counts(input string tag, input int t, input int p, input bit d);
    check({tag, "_test"}, 32'(test_count), 32'(t));
    check({tag, "_pass"}, 32'(pass_count), 32'(p));
    check({tag, "_done"}, 32'(all_done), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NC*WS-1:0] v;
    logic [NC*WS-1:0] w;
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    bus.yumi_i  = 1'b0;
    bus.data_i  = '0;
    bus.label_i = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check_result("rst", 0, 16'h0000, 1'b0);
    check_counts("rst", 0, 0, 1'b0);

    // Basic: 7 wins with 300; yumi held high through the scan.
    v = fill(16'd1);
    v[0*WS +: WS] = 16'd5;
    v[3*WS +: WS] = 16'hFFFE;
    v[7*WS +: WS] = 16'd300;
    bus.yumi_i = 1'b1;
    accept(v, 4'd7, "basic");
    check("basic_ready_low", 32'(bus.ready_o), 32'd0);
    scan_to_done("basic");
    check_result("basic", 7, 16'd300, 1'b1);
    tick();
    check("basic_drop", 32'(bus.valid_o), 32'd0);
    check("basic_ready_back", 32'(bus.ready_o), 32'd1);
    check_counts("basic", 1, 1, 1'b0);

    // Negative scores with a tie at 2 and 6: lower index wins.
    v = fill(16'hFF9C);
    v[2*WS +: WS] = 16'hFFFD;
    v[6*WS +: WS] = 16'hFFFD;
    accept(v, 4'd6, "tie");
    scan_to_done("tie");
    check_result("tie", 2, 16'hFFFD, 1'b0);
    tick();
    check_counts("tie", 2, 1, 1'b0);

    // Reset at the 4th scan edge aborts the vector and clears counters.
    v = fill(16'd0);
    v[8*WS +: WS] = 16'd77;
    accept(v, 4'd8, "abort");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", 32'(bus.valid_o), 32'd0);
    check("abort_ready", 32'(bus.ready_o), 32'd1);
    check_counts("abort", 0, 0, 1'b0);
    repeat (12) tick();
    check("abort_no_result", 32'(bus.valid_o), 32'd0);
    check("abort_test_still0", 32'(test_count), 32'd0);

    v = fill(16'd0);
    v[5*WS +: WS] = 16'd1000;
    accept(v, 4'd5, "after_rst");
    scan_to_done("after_rst");
    check_result("after_rst", 5, 16'd1000, 1'b1);
    tick();
    check_counts("after_rst", 1, 1, 1'b0);

    // Backpressure: extreme signed values, result held while yumi low.
    bus.yumi_i = 1'b0;
    v = fill(16'd0);
    v[4*WS +: WS] = 16'h7FFF;
    v[9*WS +: WS] = 16'h8000;
    for (int k = 0; k < NC; k++) w[k*WS +: WS] = WS'(k * 10 - 50);
    accept(v, 4'd1, "bp");
    scan_to_done("bp");
    check_result("bp", 4, 16'h7FFF, 1'b0);
    bus.valid_i = 1'b1;
    bus.data_i  = w;
    bus.label_i = 4'd9;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(bus.valid_o), 32'd1);
      check("bp_hold_ready", 32'(bus.ready_o), 32'd0);
      check_result("bp_hold", 4, 16'h7FFF, 1'b0);
    end
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    check("bp_drop", 32'(bus.valid_o), 32'd0);
    check("bp_ready_back", 32'(bus.ready_o), 32'd1);
    check_counts("bp", 2, 1, 1'b0);
    tick();
    bus.valid_i = 1'b0;
    check("bp_accept", 32'(bus.ready_o), 32'd0);
    scan_to_done("last_idx");
    check_result("last_idx", 9, 16'd40, 1'b1);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    check("done_ready", 32'(bus.ready_o), 32'd0);
    check_counts("done", 3, 2, 1'b1);

    // After completion a pending vector is never taken.
    bus.valid_i = 1'b1;
    bus.data_i  = fill(16'd1);
    bus.label_i = 4'd0;
    repeat (20) tick();
    check("post_ready", 32'(bus.ready_o), 32'd0);
    check("post_valid", 32'(bus.valid_o), 32'd0);
    check_counts("post", 3, 2, 1'b1);
    bus.valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
